n_term_probe: RTL and testbench

North-edge terminator tile with a built-in signal probe, used in place of the pure-wire north terminator at the top of a fabric column. It loops the north-arriving wires back south exactly like the terminator. It also watches the arriving wire bundle for a masked trigger pattern, captures a burst of consecutive samples into a small FIFO, and drains them to a host through a valid/ready port. Typical use is bring-up and debug of routing at the fabric edge.

---
 rtl/n_term_probe.sv | 195 +++++++++++++++++++
 tb/tb_n_term_probe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/n_term_probe.sv
// North-edge terminator with loopback plus a masked-trigger capture probe drained over valid/ready.
// Optional N_TERM_PROBE_LOOPBACK_REG_EN flops the S* loopback outputs (1 cycle latency, reset 0).

module n_term_probe_fifo #(
  parameter int W     = 29,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_wr_vld,
  input  logic [W-1:0] i_wr_dat,
  input  logic         i_rd_rdy,
  output logic [W-1:0] o_rd_dat,
  output logic [4:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] LP_FULL = 5'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic          w_push;
  logic          w_pop;

  // Guards make overflow/underflow impossible even if a caller misbehaves.
  assign w_push = i_wr_vld && (r_count != LP_FULL);
  assign w_pop  = i_rd_rdy && (r_count != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
endmodule

module n_term_probe #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic [3:0]  N1END,
  input  logic [7:0]  N2MID,
  input  logic [7:0]  N2END,
  input  logic [15:0] N4END,
  input  logic        Ci,
  output logic [3:0]  S1BEG,
  output logic [7:0]  S2BEG,
  output logic [7:0]  S2BEGb,
  output logic [15:0] S4BEG,
  input  logic        arm,
  input  logic        abort,
  input  logic [28:0] trig_mask,
  input  logic [28:0] trig_value,
  output logic        probe_valid,
  input  logic        probe_ready,
  output logic [31:0] probe_data,
  output logic [4:0]  probe_count,
  output logic        busy
);
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DRAIN} state_t;

  localparam logic [4:0] LP_LAST = 5'(DEPTH - 1);

  state_t      r_state;
  logic        r_busy;
  logic        r_probe_valid;
  logic [28:0] w_sample;
  logic        w_match;
  logic        w_wr;
  logic        w_pop;
  logic [28:0] w_rd_dat;
  logic [4:0]  w_count;

  assign w_sample = {Ci, N4END, N2END, N1END};
  assign w_match  = ((w_sample ^ trig_value) & trig_mask) == 29'd0;
  assign w_wr     = !abort && (((r_state == ST_ARMED) && w_match) || (r_state == ST_CAPTURE));
  assign w_pop    = r_probe_valid && probe_ready;

  n_term_probe_fifo #(.W(29), .DEPTH(DEPTH)) u_fifo (
    .clk      (CLK),
    .rst_n    (resetn),
    .i_flush  (abort),
    .i_wr_vld (w_wr),
    .i_wr_dat (w_sample),
    .i_rd_rdy (w_pop),
    .o_rd_dat (w_rd_dat),
    .o_count  (w_count)
  );

  // Capture ends on the write that fills the FIFO, so DRAIN starts DEPTH cycles after the match.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_probe_valid <= 1'b0;
    end else if (abort) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_probe_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state <= ST_ARMED;
            r_busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_match) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (w_count == LP_LAST) begin
            r_state       <= ST_DRAIN;
            r_probe_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_pop && (w_count == 5'd1)) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_probe_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_busy        <= 1'b0;
          r_probe_valid <= 1'b0;
        end
      endcase
    end
  end

  assign probe_valid = r_probe_valid;
  assign probe_data  = {3'b000, w_rd_dat};
  assign probe_count = w_count;
  assign busy        = r_busy;

`ifdef N_TERM_PROBE_LOOPBACK_REG_EN
  logic [3:0]  r_s1;
  logic [7:0]  r_s2;
  logic [7:0]  r_s2b;
  logic [15:0] r_s4;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s2b <= '0;
      r_s4  <= '0;
    end else begin
      r_s1  <= N1END;
      r_s2  <= N2MID;
      r_s2b <= N2END;
      r_s4  <= N4END;
    end
  end

  assign S1BEG  = r_s1;
  assign S2BEG  = r_s2;
  assign S2BEGb = r_s2b;
  assign S4BEG  = r_s4;
`else
  assign S1BEG  = N1END;
  assign S2BEG  = N2MID;
  assign S2BEGb = N2END;
  assign S4BEG  = N4END;
`endif
endmodule

// File: tb/tb_n_term_probe.sv
// Directed bench for n_term_probe (default build, DEPTH=4): loopback, triggers, backpressure, abort, reset.
module tb_n_term_probe;
  logic        CLK = 1'b0;
  logic        resetn;
  logic [3:0]  N1END;
  logic [7:0]  N2MID;
  logic [7:0]  N2END;
  logic [15:0] N4END;
  logic        Ci;
  logic [3:0]  S1BEG;
  logic [7:0]  S2BEG;
  logic [7:0]  S2BEGb;
  logic [15:0] S4BEG;
  logic        arm;
  logic        abort;
  logic [28:0] trig_mask;
  logic [28:0] trig_value;
  logic        probe_valid;
  logic        probe_ready;
  logic [31:0] probe_data;
  logic [4:0]  probe_count;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  n_term_probe #(.DEPTH(4)) dut (
    .CLK(CLK), .resetn(resetn),
    .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .Ci(Ci),
    .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG),
    .arm(arm), .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value),
    .probe_valid(probe_valid), .probe_ready(probe_ready), .probe_data(probe_data),
    .probe_count(probe_count), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; N1END = '0; N2MID = '0; N2END = '0; N4END = '0; Ci = 1'b0;
    arm = 1'b0; abort = 1'b0; trig_mask = '0; trig_value = '0; probe_ready = 1'b0;

    // Reset state
    @(negedge CLK); @(negedge CLK);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_valid", 32'(probe_valid), 32'd0);
    chk("rst_count", 32'(probe_count), 32'd0);
    chk("rst_data",  probe_data, 32'd0);

    // Combinational loopback
    N4END = 16'hA5C3; N1END = 4'h9; N2MID = 8'h3C; N2END = 8'hE1;
    #1;
    chk("loop_s4",  32'(S4BEG), 32'h0000A5C3);
    chk("loop_s1",  32'(S1BEG), 32'h9);
    chk("loop_s2",  32'(S2BEG), 32'h3C);
    chk("loop_s2b", 32'(S2BEGb), 32'hE1);
    @(negedge CLK);
    resetn = 1'b1; N4END = '0; N1END = '0; N2MID = '0; N2END = '0;

    // Immediate trigger, mask = 0
    @(negedge CLK);
    trig_mask = '0; trig_value = '0; arm = 1'b1; probe_ready = 1'b1;
    @(negedge CLK);
    arm = 1'b0; N1END = 4'd0;
    chk("imm_busy_armed", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      chk("imm_no_valid_capture", 32'(probe_valid), 32'd0);
      N1END = 4'(i);
    end
    @(negedge CLK);
    N1END = 4'd0;
    for (int i = 0; i < 4; i++) begin
      chk("imm_valid", 32'(probe_valid), 32'd1);
      chk("imm_data",  probe_data, 32'(i));
      chk("imm_count", 32'(probe_count), 32'(4 - i));
      @(negedge CLK);
    end
    chk("imm_busy_done",  32'(busy), 32'd0);
    chk("imm_valid_done", 32'(probe_valid), 32'd0);

    // Masked trigger on sample bit 4 (N2END[0])
    probe_ready = 1'b0;
    trig_mask = 29'h10; trig_value = 29'h10; arm = 1'b1; N1END = '0; N2END = '0;
    @(negedge CLK);
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("mask_wait_busy",  32'(busy), 32'd1);
      chk("mask_wait_count", 32'(probe_count), 32'd0);
      @(negedge CLK);
    end
    N2END = 8'h01; N1END = 4'd0;
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK);
      chk("mask_valid_low", 32'(probe_valid), 32'd0);
      chk("mask_count_fill", 32'(probe_count), 32'(k));
      N1END = 4'(k + 4);
    end
    @(negedge CLK);
    N2END = '0; N1END = '0;
    chk("mask_valid_rise", 32'(probe_valid), 32'd1);
    chk("mask_entry0",     probe_data, 32'h10);

    // Backpressure: ready low holds head and count
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data",  probe_data, 32'h10);
      chk("bp_hold_count", 32'(probe_count), 32'd4);
      chk("bp_hold_valid", 32'(probe_valid), 32'd1);
      @(negedge CLK);
    end
    probe_ready = 1'b1;
    @(negedge CLK); probe_ready = 1'b0;
    chk("bp_pop1_count", 32'(probe_count), 32'd3);
    chk("bp_pop1_data",  probe_data, 32'h15);
    @(negedge CLK); probe_ready = 1'b1;
    chk("bp_gap1_count", 32'(probe_count), 32'd3);
    @(negedge CLK); probe_ready = 1'b0;
    chk("bp_pop2_count", 32'(probe_count), 32'd2);
    chk("bp_pop2_data",  probe_data, 32'h16);
    @(negedge CLK); probe_ready = 1'b1;
    chk("bp_gap2_data",  probe_data, 32'h16);
    @(negedge CLK); probe_ready = 1'b0;
    chk("bp_pop3_count", 32'(probe_count), 32'd1);
    chk("bp_pop3_data",  probe_data, 32'h17);
    @(negedge CLK); probe_ready = 1'b1;
    @(negedge CLK); probe_ready = 1'b0;
    chk("bp_pop4_count", 32'(probe_count), 32'd0);
    chk("bp_pop4_busy",  32'(busy), 32'd0);
    chk("bp_pop4_valid", 32'(probe_valid), 32'd0);

    // Abort during CAPTURE with 2 entries; simultaneous arm is ignored
    trig_mask = '0; trig_value = '0; arm = 1'b1;
    @(negedge CLK);
    arm = 1'b0;
    @(negedge CLK);
    chk("abort_cnt1", 32'(probe_count), 32'd1);
    @(negedge CLK);
    chk("abort_cnt2", 32'(probe_count), 32'd2);
    abort = 1'b1; arm = 1'b1;
    @(negedge CLK);
    abort = 1'b0; arm = 1'b0;
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_count", 32'(probe_count), 32'd0);
    chk("abort_valid", 32'(probe_valid), 32'd0);
    @(negedge CLK);
    chk("abort_arm_ignored", 32'(busy), 32'd0);

    // Reset mid-DRAIN with 3 entries left
    arm = 1'b1; N1END = 4'd4;
    @(negedge CLK);
    arm = 1'b0; N1END = 4'd4;
    @(negedge CLK); N1END = 4'd5;
    @(negedge CLK); N1END = 4'd6;
    @(negedge CLK); N1END = 4'd7;
    @(negedge CLK); N1END = 4'd0;
    chk("rd_full", 32'(probe_count), 32'd4);
    probe_ready = 1'b1;
    @(negedge CLK); probe_ready = 1'b0;
    chk("rd_cnt3",  32'(probe_count), 32'd3);
    chk("rd_data5", probe_data, 32'h5);
    resetn = 1'b0;
    #1;
    chk("rd_rst_busy",  32'(busy), 32'd0);
    chk("rd_rst_valid", 32'(probe_valid), 32'd0);
    chk("rd_rst_count", 32'(probe_count), 32'd0);
    chk("rd_rst_data",  probe_data, 32'd0);
    @(negedge CLK);
    resetn = 1'b1;

    // Re-arm after reset
    @(negedge CLK);
    arm = 1'b1; probe_ready = 1'b1;
    @(negedge CLK);
    arm = 1'b0; N1END = 4'h8;
    @(negedge CLK); N1END = 4'h9;
    @(negedge CLK); N1END = 4'hA;
    @(negedge CLK); N1END = 4'hB;
    @(negedge CLK); N1END = 4'h0;
    for (int i = 0; i < 4; i++) begin
      chk("rearm_data",  probe_data, 32'(8 + i));
      chk("rearm_valid", 32'(probe_valid), 32'd1);
      @(negedge CLK);
    end
    chk("rearm_busy_done", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
